// File: rtl/final_soc_pio_poller.sv
// rtl/final_soc_pio_poller.sv - Avalon-MM PIO poller with debounce, rise event and press counter
//
// Periodically reads bit 0 of a single-bit PIO slave at address 0, filters
// the sampled level, emits a one-cycle rise event and counts presses.
// Optional feature macro: PIO_POLLER_DEBOUNCE_EN (undefined: every sample
// is taken as the new level, DEBOUNCE_N is not used).

module final_soc_pio_poller #(
    parameter int POLL_DIV     = 50000,
    parameter int READ_LATENCY = 1,
    parameter int DEBOUNCE_N   = 4
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        enable,
    output logic [1:0]  avm_address,
    output logic        avm_read,
    input  logic [31:0] avm_readdata,
    input  logic        count_clr,
    output logic        sample_strobe,
    output logic        level,
    output logic        rise_pulse,
    output logic [15:0] press_count
);

    localparam int PW = (POLL_DIV > 1) ? $clog2(POLL_DIV) : 1;
    localparam int LW = $clog2(READ_LATENCY + 1);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        REQ    = 2'd1,
        LAT    = 2'd2,
        SAMPLE = 2'd3
    } state_t;

    state_t         state_q;
    logic [PW-1:0]  poll_cnt_q;
    logic [PW-1:0]  poll_cnt_d;
    logic [LW-1:0]  lat_cnt_q;
    logic           avm_read_q;
    logic           sample_strobe_q;
    logic           level_q;
    logic           level_d;
    logic           rise_q;
    logic           rise_d;
    logic [15:0]    press_cnt_q;
    logic [15:0]    press_cnt_d;
    logic           sample_bit;
    logic           sample_fire;

`ifdef PIO_POLLER_DEBOUNCE_EN
    localparam int DW = $clog2(DEBOUNCE_N + 1);
    logic [DW-1:0]  deb_cnt_q;
    logic [DW-1:0]  deb_cnt_d;
`else
    localparam int unused_debounce_n = DEBOUNCE_N;
`endif

    // Only bit 0 of the PIO readdata carries information.
    logic unused_readdata;
    assign unused_readdata = ^avm_readdata[31:1];

    assign sample_bit  = avm_readdata[0];
    assign sample_fire = (state_q == SAMPLE);

    // Poll counter: reload on the IDLE->REQ launch, otherwise count down to 0
    // so the REQ-to-REQ spacing is exactly POLL_DIV cycles.
    always_comb begin
        poll_cnt_d = poll_cnt_q;
        if (state_q == IDLE && poll_cnt_q == '0 && enable) begin
            poll_cnt_d = PW'(POLL_DIV - 1);
        end else if (poll_cnt_q != '0) begin
            poll_cnt_d = poll_cnt_q - 1'b1;
        end
    end

    // Level filter and rise detection, evaluated only while the sample is captured.
    always_comb begin
        level_d = level_q;
        rise_d  = 1'b0;
`ifdef PIO_POLLER_DEBOUNCE_EN
        deb_cnt_d = deb_cnt_q;
        if (sample_fire) begin
            if (sample_bit == level_q) begin
                deb_cnt_d = '0;
            end else if (deb_cnt_q == DW'(DEBOUNCE_N - 1)) begin
                level_d   = sample_bit;
                deb_cnt_d = '0;
                rise_d    = sample_bit;
            end else begin
                deb_cnt_d = deb_cnt_q + 1'b1;
            end
        end
`else
        if (sample_fire) begin
            level_d = sample_bit;
            rise_d  = sample_bit & ~level_q;
        end
`endif
    end

    // Press counter: a clear that coincides with a rise keeps that rise.
    always_comb begin
        press_cnt_d = press_cnt_q;
        if (count_clr) begin
            press_cnt_d = rise_d ? 16'd1 : 16'd0;
        end else if (rise_d && press_cnt_q != 16'hFFFF) begin
            press_cnt_d = press_cnt_q + 16'd1;
        end
    end

    // Read sequencer with registered strobes; a reset drops any in-flight read.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q         <= IDLE;
            poll_cnt_q      <= '0;
            lat_cnt_q       <= '0;
            avm_read_q      <= 1'b0;
            sample_strobe_q <= 1'b0;
        end else begin
            poll_cnt_q      <= poll_cnt_d;
            avm_read_q      <= 1'b0;
            sample_strobe_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (poll_cnt_q == '0 && enable) begin
                        state_q    <= REQ;
                        avm_read_q <= 1'b1;
                    end
                end
                REQ: begin
                    if (READ_LATENCY == 1) begin
                        state_q         <= SAMPLE;
                        sample_strobe_q <= 1'b1;
                    end else begin
                        state_q   <= LAT;
                        lat_cnt_q <= LW'(READ_LATENCY - 2);
                    end
                end
                LAT: begin
                    if (lat_cnt_q == '0) begin
                        state_q         <= SAMPLE;
                        sample_strobe_q <= 1'b1;
                    end else begin
                        lat_cnt_q <= lat_cnt_q - 1'b1;
                    end
                end
                SAMPLE: begin
                    state_q <= IDLE;
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    // Filtered level, rise event and press count registers.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            level_q     <= 1'b0;
            rise_q      <= 1'b0;
            press_cnt_q <= 16'd0;
`ifdef PIO_POLLER_DEBOUNCE_EN
            deb_cnt_q   <= '0;
`endif
        end else begin
            level_q     <= level_d;
            rise_q      <= rise_d;
            press_cnt_q <= press_cnt_d;
`ifdef PIO_POLLER_DEBOUNCE_EN
            deb_cnt_q   <= deb_cnt_d;
`endif
        end
    end

    assign avm_address   = 2'd0;
    assign avm_read      = avm_read_q;
    assign sample_strobe = sample_strobe_q;
    assign level         = level_q;
    assign rise_pulse    = rise_q;
    assign press_count   = press_cnt_q;

endmodule

// File: tb/tb_final_soc_pio_poller.sv
// tb/tb_final_soc_pio_poller.sv - self-checking bench for final_soc_pio_poller
module tb_final_soc_pio_poller;

    localparam int POLL_DIV     = 8;
    localparam int READ_LATENCY = 1;
    localparam int DEBOUNCE_N   = 3;
`ifdef PIO_POLLER_DEBOUNCE_EN
    localparam int NS = DEBOUNCE_N;
`else
    localparam int NS = 1;
`endif

    logic        clk = 1'b0;
    logic        reset_n;
    logic        enable;
    logic [1:0]  avm_address;
    logic        avm_read;
    logic [31:0] avm_readdata = 32'd0;
    logic        count_clr;
    logic        sample_strobe;
    logic        level;
    logic        rise_pulse;
    logic [15:0] press_count;

    logic        pio_bit;
    int          cyc = 0;
    int          expect_req_cyc;
    int          n_cmp = 0;
    int          n_fail = 0;
    int          cur;

    typedef struct {
        bit          s;
        bit          clr;
        bit          lvl;
        bit          rise;
        logic [15:0] cnt;
    } vec_t;

    vec_t tbl [15];

    final_soc_pio_poller #(
        .POLL_DIV(POLL_DIV),
        .READ_LATENCY(READ_LATENCY),
        .DEBOUNCE_N(DEBOUNCE_N)
    ) dut (
        .clk(clk),
        .reset_n(reset_n),
        .enable(enable),
        .avm_address(avm_address),
        .avm_read(avm_read),
        .avm_readdata(avm_readdata),
        .count_clr(count_clr),
        .sample_strobe(sample_strobe),
        .level(level),
        .rise_pulse(rise_pulse),
        .press_count(press_count)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Registered-readdata PIO slave; upper bits carry junk that must be ignored.
    always @(posedge clk) begin
        if (avm_read) avm_readdata <= {31'h2AAAAAAA, pio_bit};
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic wait_req(input string nm);
        int n = 0;
        while (avm_read !== 1'b1 && n < 20) begin
            @(negedge clk);
            n++;
        end
        if (avm_read !== 1'b1) begin
            chk({nm, "_req_timeout"}, 32'd0, 32'd1);
        end else begin
            chk({nm, "_req_cycle"}, cyc, expect_req_cyc);
            chk({nm, "_addr"}, avm_address, 32'd0);
        end
        expect_req_cyc = cyc + POLL_DIV;
    endtask

    task automatic poll(input bit s, input bit clr, input bit lvl, input bit rise,
                        input logic [15:0] cnt, input string nm);
        pio_bit = s;
        wait_req(nm);
        @(negedge clk);
        chk({nm, "_strobe"}, sample_strobe, 32'd1);
        chk({nm, "_read_1cyc"}, avm_read, 32'd0);
        count_clr = clr;
        @(negedge clk);
        count_clr = 1'b0;
        chk({nm, "_level"}, level, lvl);
        chk({nm, "_rise"}, rise_pulse, rise);
        chk({nm, "_count"}, press_count, cnt);
        @(negedge clk);
        chk({nm, "_rise_off"}, rise_pulse, 32'd0);
        chk({nm, "_strobe_off"}, sample_strobe, 32'd0);
    endtask

    // One full press and release starting from level 0.
    task automatic press(input string nm);
        for (int j = 0; j < NS - 1; j++) poll(1'b1, 1'b0, 1'b0, 1'b0, cur[15:0], {nm, "_hi"});
        cur++;
        poll(1'b1, 1'b0, 1'b1, 1'b1, cur[15:0], {nm, "_rise"});
        for (int j = 0; j < NS - 1; j++) poll(1'b0, 1'b0, 1'b1, 1'b0, cur[15:0], {nm, "_lo"});
        poll(1'b0, 1'b0, 1'b0, 1'b0, cur[15:0], {nm, "_fall"});
    endtask

    initial begin
`ifdef PIO_POLLER_DEBOUNCE_EN
        tbl[0]  = '{1'b1, 1'b0, 1'b0, 1'b0, 16'd0};
        tbl[1]  = '{1'b1, 1'b0, 1'b0, 1'b0, 16'd0};
        tbl[2]  = '{1'b1, 1'b0, 1'b1, 1'b1, 16'd1};
        tbl[3]  = '{1'b0, 1'b0, 1'b1, 1'b0, 16'd1};
        tbl[4]  = '{1'b0, 1'b0, 1'b1, 1'b0, 16'd1};
        tbl[5]  = '{1'b0, 1'b0, 1'b0, 1'b0, 16'd1};
        tbl[6]  = '{1'b1, 1'b0, 1'b0, 1'b0, 16'd1};
        tbl[7]  = '{1'b1, 1'b0, 1'b0, 1'b0, 16'd1};
        tbl[8]  = '{1'b0, 1'b0, 1'b0, 1'b0, 16'd1};
        tbl[9]  = '{1'b1, 1'b1, 1'b0, 1'b0, 16'd0};
        tbl[10] = '{1'b1, 1'b0, 1'b0, 1'b0, 16'd0};
        tbl[11] = '{1'b1, 1'b0, 1'b1, 1'b1, 16'd1};
        tbl[12] = '{1'b0, 1'b0, 1'b1, 1'b0, 16'd1};
        tbl[13] = '{1'b0, 1'b0, 1'b1, 1'b0, 16'd1};
        tbl[14] = '{1'b0, 1'b0, 1'b0, 1'b0, 16'd1};
`else
        tbl[0]  = '{1'b1, 1'b0, 1'b1, 1'b1, 16'd1};
        tbl[1]  = '{1'b1, 1'b0, 1'b1, 1'b0, 16'd1};
        tbl[2]  = '{1'b1, 1'b0, 1'b1, 1'b0, 16'd1};
        tbl[3]  = '{1'b0, 1'b0, 1'b0, 1'b0, 16'd1};
        tbl[4]  = '{1'b0, 1'b0, 1'b0, 1'b0, 16'd1};
        tbl[5]  = '{1'b0, 1'b0, 1'b0, 1'b0, 16'd1};
        tbl[6]  = '{1'b1, 1'b0, 1'b1, 1'b1, 16'd2};
        tbl[7]  = '{1'b1, 1'b0, 1'b1, 1'b0, 16'd2};
        tbl[8]  = '{1'b0, 1'b0, 1'b0, 1'b0, 16'd2};
        tbl[9]  = '{1'b1, 1'b1, 1'b1, 1'b1, 16'd1};
        tbl[10] = '{1'b1, 1'b0, 1'b1, 1'b0, 16'd1};
        tbl[11] = '{1'b1, 1'b0, 1'b1, 1'b0, 16'd1};
        tbl[12] = '{1'b0, 1'b0, 1'b0, 1'b0, 16'd1};
        tbl[13] = '{1'b0, 1'b0, 1'b0, 1'b0, 16'd1};
        tbl[14] = '{1'b0, 1'b0, 1'b0, 1'b0, 16'd1};
`endif

        reset_n   = 1'b0;
        enable    = 1'b0;
        count_clr = 1'b0;
        pio_bit   = 1'b0;
        repeat (2) @(negedge clk);
        chk("rst_read", avm_read, 32'd0);
        chk("rst_addr", avm_address, 32'd0);
        chk("rst_strobe", sample_strobe, 32'd0);
        chk("rst_level", level, 32'd0);
        chk("rst_rise", rise_pulse, 32'd0);
        chk("rst_count", press_count, 32'd0);

        reset_n = 1'b1;
        enable  = 1'b1;
        expect_req_cyc = cyc + 1;
        for (int i = 0; i < 15; i++) begin
            poll(tbl[i].s, tbl[i].clr, tbl[i].lvl, tbl[i].rise, tbl[i].cnt,
                 $sformatf("vec%0d", i));
        end
        cur = int'(tbl[14].cnt);

        // Build the count up to 5, then a rise together with count_clr.
        while (cur < 5) press($sformatf("press%0d", cur + 1));
        for (int j = 0; j < NS - 1; j++) poll(1'b1, 1'b0, 1'b0, 1'b0, cur[15:0], "coll_hi");
        poll(1'b1, 1'b1, 1'b1, 1'b1, 16'd1, "coll_rise");
        cur = 1;

        // Dropping enable during a read lets the read finish, then polling stops.
        pio_bit = 1'b1;
        wait_req("en");
        enable = 1'b0;
        @(negedge clk);
        chk("en_inflight_strobe", sample_strobe, 32'd1);
        @(negedge clk);
        chk("en_inflight_level", level, 32'd1);
        chk("en_inflight_count", press_count, 32'd1);
        begin
            int hits = 0;
            repeat (12) begin
                @(negedge clk);
                if (avm_read) hits++;
            end
            chk("en_low_no_req", hits, 32'd0);
        end
        enable = 1'b1;
        @(negedge clk);
        chk("en_resume_req", avm_read, 32'd1);

        // Reset asserted while the read strobe is high.
        reset_n = 1'b0;
        #1;
        chk("midrst_read", avm_read, 32'd0);
        chk("midrst_strobe", sample_strobe, 32'd0);
        chk("midrst_level", level, 32'd0);
        chk("midrst_count", press_count, 32'd0);
        repeat (2) @(negedge clk);
        chk("midrst_hold_read", avm_read, 32'd0);
        reset_n = 1'b1;
        expect_req_cyc = cyc + 1;
        cur = 0;
        press("postrst");
        poll(1'b0, 1'b1, 1'b0, 1'b0, 16'd0, "clr_alone");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
